// File: rtl/sync_mem.sv
// rtl/sync_mem.sv - single-port synchronous read/write memory with resettable flop array
module sync_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage lives in flops so that reset can clear every word.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_word;

  // Read mux: an address that matches no word (addr >= DEPTH) yields zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        rd_word = mem_q[i];
      end
    end
  end

  // Next read-data value: loads on reads, holds across writes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (!wr_rd) begin
      rd_data_d = rd_word;
    end
  end

  // Array update: reset clears every word; a write lands only on a matching in-range word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if (wr_rd && (addr == ADDR_WIDTH'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Registered read data, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sync_mem.sv
// tb/tb_sync_mem.sv - self-checking scoreboard bench for sync_mem (full and partial depth)
module tb_sync_mem;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] addr_a, addr_b;
  logic       wr_rd_a, wr_rd_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic [7:0] rd_data_a, rd_data_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [2][16];
  logic [7:0] last_rd [2];
  int         depth [2];
  logic [7:0] exp_q [$];

  sync_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) u_full (
    .clk(clk), .rst(rst_a), .addr(addr_a), .wr_rd(wr_rd_a),
    .wr_data(wr_data_a), .rd_data(rd_data_a)
  );

  sync_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) u_part (
    .clk(clk), .rst(rst_b), .addr(addr_b), .wr_rd(wr_rd_b),
    .wr_data(wr_data_b), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int s, input string tag, input logic [7:0] e);
    logic [7:0] obs;
    obs = (s == 0) ? rd_data_a : rd_data_b;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, s, obs, e);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic [3:0] a, input logic w, input logic [7:0] d);
    if (s == 0) begin
      rst_a = r; addr_a = a; wr_rd_a = w; wr_data_a = d;
    end else begin
      rst_b = r; addr_b = a; wr_rd_b = w; wr_data_b = d;
    end
  endtask

  // One access; reads push their expected word, which is popped once the DUT presents it.
  task automatic op(input int s, input logic [3:0] a, input logic w, input logic [7:0] d, input string tag);
    logic [7:0] e;
    drive(s, 1'b0, a, w, d);
    if (!w) begin
      exp_q.push_back((int'(a) < depth[s]) ? model[s][a] : 8'h00);
    end else if (int'(a) < depth[s]) begin
      model[s][a] = d;
    end
    @(posedge clk); #1;
    if (!w) begin
      e = exp_q.pop_front();
      last_rd[s] = e;
      check(s, tag, e);
    end else begin
      check(s, {tag, "_hold"}, last_rd[s]);
    end
  endtask

  task automatic rst_cycle(input int s, input logic [3:0] a, input logic w, input logic [7:0] d, input string tag);
    drive(s, 1'b1, a, w, d);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) model[s][i] = 8'h00;
    last_rd[s] = 8'h00;
    check(s, tag, 8'h00);
    drive(s, 1'b0, 4'd0, 1'b0, 8'h00);
  endtask

  initial begin
    depth[0] = 16;
    depth[1] = 12;
    rst_a = 1'b1; addr_a = '0; wr_rd_a = 1'b0; wr_data_a = '0;
    rst_b = 1'b1; addr_b = '0; wr_rd_b = 1'b0; wr_data_b = '0;

    // Full-depth instance
    rst_cycle(0, 4'd0, 1'b0, 8'h00, "rst1");
    rst_cycle(0, 4'd0, 1'b0, 8'h00, "rst2");
    for (int i = 0; i < 16; i++) op(0, 4'(i), 1'b0, 8'h00, "rst_rd");
    for (int i = 0; i < 16; i++) op(0, 4'(i), 1'b1, 8'(i * 17), "wr");
    for (int i = 0; i < 16; i++) op(0, 4'(i), 1'b0, 8'h00, "rdback");
    op(0, 4'd3, 1'b1, 8'hA5, "raw_wr");
    op(0, 4'd3, 1'b0, 8'h00, "raw_rd");
    op(0, 4'd3, 1'b1, 8'h5A, "wr_after_rd");
    op(0, 4'd3, 1'b0, 8'h00, "raw_rd2");
    op(0, 4'd7, 1'b1, 8'h12, "ovw1");
    op(0, 4'd7, 1'b1, 8'h34, "ovw2");
    op(0, 4'd7, 1'b0, 8'h00, "ovw_rd");
    for (int i = 0; i < 16; i++) op(0, 4'(i), 1'b1, 8'hFF, "fill");
    op(0, 4'd5, 1'b0, 8'h00, "fill_rd");
    rst_cycle(0, 4'd2, 1'b1, 8'h77, "mid_rst");
    op(0, 4'd2, 1'b0, 8'h00, "mid_rd2");
    op(0, 4'd9, 1'b0, 8'h00, "mid_rd9");

    // Partial-depth instance
    rst_cycle(1, 4'd0, 1'b0, 8'h00, "p_rst1");
    rst_cycle(1, 4'd0, 1'b0, 8'h00, "p_rst2");
    for (int i = 0; i < 12; i++) op(1, 4'(i), 1'b1, 8'(i * 17), "p_wr");
    op(1, 4'd13, 1'b1, 8'h99, "p_oor_wr");
    op(1, 4'd13, 1'b0, 8'h00, "p_oor_rd");
    for (int i = 0; i < 12; i++) op(1, 4'(i), 1'b0, 8'h00, "p_rdback");
    op(1, 4'd15, 1'b0, 8'h00, "p_oor_rd15");
    op(1, 4'd11, 1'b0, 8'h00, "p_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
